// File: rtl/video_source_arbiter.sv
//------------------------------------------------------------------------------
// video_source_arbiter: shares one DVI sink between two pixel streams and only
// switches source at frame boundaries. Option macro: BLANK_ON_UNDERRUN_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module video_source_arbiter #(
   parameter int H_ACTIVE = 800,
   parameter int V_ACTIVE = 600,
   parameter int DATA_W   = 24,
   parameter int CNT_W    = 16,
   localparam int X_W     = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1,
   localparam int Y_W     = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              sel_req,
   input  logic              src0_valid,
   input  logic [DATA_W-1:0] src0_video,
   output logic              src0_ready,
   input  logic              src1_valid,
   input  logic [DATA_W-1:0] src1_video,
   output logic              src1_ready,
   input  logic              VideoReady,
   output logic              VideoValid,
   output logic [DATA_W-1:0] Video,
   output logic              active_sel,
   output logic [X_W-1:0]    pix_x,
   output logic [Y_W-1:0]    pix_y,
   output logic              frame_start,
   output logic              frame_done,
   output logic [CNT_W-1:0]  underrun_count
);

   localparam logic [X_W-1:0] X_LAST = X_W'(H_ACTIVE - 1);
   localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_ACTIVE - 1);

   logic              active_sel_q, active_sel_d;
   logic [X_W-1:0]    pix_x_q, pix_x_d;
   logic [Y_W-1:0]    pix_y_q, pix_y_d;
   logic              frame_done_q, frame_done_d;

   logic              sel_valid;
   logic [DATA_W-1:0] sel_video;
   logic              out_valid;
   logic [DATA_W-1:0] out_video;
   logic              xfer;

   assign sel_valid = active_sel_q ? src1_valid : src0_valid;
   assign sel_video = active_sel_q ? src1_video : src0_video;

   // Outputs are gated by the reset input itself so the sink sees nothing
   // for the whole time reset is held, not just after the first edge.
`ifdef BLANK_ON_UNDERRUN_EN
   assign out_valid = reset;
   assign out_video = sel_valid ? sel_video : '0;
`else
   assign out_valid = reset & sel_valid;
   assign out_video = sel_video;
`endif

   assign VideoValid = out_valid;
   assign Video      = reset ? out_video : '0;
   assign src0_ready = reset & ~active_sel_q & VideoReady;
   assign src1_ready = reset &  active_sel_q & VideoReady;
   assign xfer       = out_valid & VideoReady;

   always_comb begin
      pix_x_d      = pix_x_q;
      pix_y_d      = pix_y_q;
      active_sel_d = active_sel_q;
      frame_done_d = 1'b0;
      if (xfer) begin
         if (pix_x_q == X_LAST) begin
            pix_x_d = '0;
            if (pix_y_q == Y_LAST) begin
               pix_y_d      = '0;
               frame_done_d = 1'b1;
               active_sel_d = sel_req;
            end else begin
               pix_y_d = pix_y_q + 1'b1;
            end
         end else begin
            pix_x_d = pix_x_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         active_sel_q <= 1'b0;
         pix_x_q      <= '0;
         pix_y_q      <= '0;
         frame_done_q <= 1'b0;
      end else begin
         active_sel_q <= active_sel_d;
         pix_x_q      <= pix_x_d;
         pix_y_q      <= pix_y_d;
         frame_done_q <= frame_done_d;
      end
   end

`ifdef BLANK_ON_UNDERRUN_EN
   logic [CNT_W-1:0] underrun_q, underrun_d;

   // Saturating: a long underrun must never read back as a small count.
   always_comb begin
      underrun_d = underrun_q;
      if (xfer && !sel_valid && (underrun_q != {CNT_W{1'b1}})) begin
         underrun_d = underrun_q + 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         underrun_q <= '0;
      end else begin
         underrun_q <= underrun_d;
      end
   end

   assign underrun_count = underrun_q;
`else
   assign underrun_count = '0;
`endif

   assign active_sel  = active_sel_q;
   assign pix_x       = pix_x_q;
   assign pix_y       = pix_y_q;
   assign frame_start = (pix_x_q == '0) && (pix_y_q == '0);
   assign frame_done  = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_video_source_arbiter.sv
//------------------------------------------------------------------------------
// tb_video_source_arbiter: randomized bench with a frame-level reference model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_video_source_arbiter;

   localparam int H   = 4;
   localparam int V   = 3;
   localparam int DW  = 24;
   localparam int CW  = 16;
   localparam int N   = H * V;
   localparam int SAT = (1 << CW) - 1;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          sel_req = 1'b0;
   logic          src0_valid = 1'b0;
   logic [DW-1:0] src0_video = '0;
   logic          src0_ready;
   logic          src1_valid = 1'b0;
   logic [DW-1:0] src1_video = '0;
   logic          src1_ready;
   logic          VideoReady = 1'b0;
   logic          VideoValid;
   logic [DW-1:0] Video;
   logic          active_sel;
   logic [1:0]    pix_x;
   logic [1:0]    pix_y;
   logic          frame_start;
   logic          frame_done;
   logic [CW-1:0] underrun_count;

   video_source_arbiter #(
      .H_ACTIVE(H), .V_ACTIVE(V), .DATA_W(DW), .CNT_W(CW)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .sel_req        (sel_req),
      .src0_valid     (src0_valid),
      .src0_video     (src0_video),
      .src0_ready     (src0_ready),
      .src1_valid     (src1_valid),
      .src1_video     (src1_video),
      .src1_ready     (src1_ready),
      .VideoReady     (VideoReady),
      .VideoValid     (VideoValid),
      .Video          (Video),
      .active_sel     (active_sel),
      .pix_x          (pix_x),
      .pix_y          (pix_y),
      .frame_start    (frame_start),
      .frame_done     (frame_done),
      .underrun_count (underrun_count)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: frame owner, linear pixel index within the frame,
   // done flag, underrun tally; source streams are plain counters.
   int m_sel   = 0;
   int m_n     = 0;
   int m_done  = 0;
   int m_under = 0;
   int d0 = 0;
   int d1 = 0;
   bit hold0 = 0;
   bit hold1 = 0;
   int p_valid = 100;
   int p_ready = 100;
   int p_sel   = 0;

   task automatic cycle(input bit rst_now);
      bit            sv, e_valid, e_r0, e_r1, xfer, acc0, acc1;
      logic [DW-1:0] sd, e_video;
      @(negedge clock);
      reset      = ~rst_now;
      src0_valid = hold0 ? 1'b1 : ($urandom_range(99) < p_valid);
      src1_valid = hold1 ? 1'b1 : ($urandom_range(99) < p_valid);
      src0_video = DW'(d0);
      src1_video = DW'(32'h800000 + d1);
      VideoReady = ($urandom_range(99) < p_ready);
      if (p_sel > 0 && $urandom_range(99) < p_sel) sel_req = ~sel_req;
      if (rst_now) begin
         m_sel = 0; m_n = 0; m_done = 0; m_under = 0;
      end
      #1;
      sv = (m_sel != 0) ? src1_valid : src0_valid;
      sd = (m_sel != 0) ? src1_video : src0_video;
      if (rst_now) begin
         e_valid = 0; e_video = '0; e_r0 = 0; e_r1 = 0;
      end else begin
`ifdef BLANK_ON_UNDERRUN_EN
         e_valid = 1;
         e_video = sv ? sd : '0;
`else
         e_valid = sv;
         e_video = sd;
`endif
         e_r0 = (m_sel == 0) && VideoReady;
         e_r1 = (m_sel != 0) && VideoReady;
      end
      check("VideoValid",  32'(VideoValid), 32'(e_valid));
      check("Video",       32'(Video), 32'(e_video));
      check("src0_ready",  32'(src0_ready), 32'(e_r0));
      check("src1_ready",  32'(src1_ready), 32'(e_r1));
      check("pix_x",       32'(pix_x), 32'(m_n % H));
      check("pix_y",       32'(pix_y), 32'(m_n / H));
      check("frame_start", 32'(frame_start), 32'(m_n == 0));
      check("frame_done",  32'(frame_done), 32'(m_done));
      check("active_sel",  32'(active_sel), 32'(m_sel));
      check("underrun",    32'(underrun_count), 32'(m_under));
      xfer  = e_valid && VideoReady;
      acc0  = src0_valid && e_r0;
      acc1  = src1_valid && e_r1;
      hold0 = src0_valid && !acc0;
      hold1 = src1_valid && !acc1;
      @(posedge clock);
      if (!rst_now) begin
         m_done = 0;
         if (xfer) begin
            if (!sv && m_under < SAT) m_under++;
            if (m_n == N - 1) begin
               m_n    = 0;
               m_done = 1;
               m_sel  = int'(sel_req);
            end else begin
               m_n++;
            end
         end
         if (acc0) d0++;
         if (acc1) d1++;
      end
   endtask

   initial begin
      // Held reset with live source and sink, then one clean frame of src0.
      p_valid = 100; p_ready = 100; p_sel = 0;
      repeat (3) cycle(1'b1);
      repeat (N + 2) cycle(1'b0);
      // Request src1 mid-frame; it must take effect only at the frame end.
      repeat (3) cycle(1'b0);
      sel_req = 1'b1;
      repeat (2 * N) cycle(1'b0);
      // Alternating sink stalls, then back to src0.
      sel_req = 1'b0;
      p_ready = 50;
      repeat (3 * N) cycle(1'b0);
      // Fully random traffic with occasional source requests and resets.
      p_valid = 80; p_ready = 70; p_sel = 8;
      for (int i = 0; i < 1500; i++) begin
         cycle($urandom_range(199) == 0);
      end
      // Mid-frame reset after some progress.
      p_valid = 100; p_ready = 100; p_sel = 0;
      repeat (7) cycle(1'b0);
      repeat (2) cycle(1'b1);
      repeat (N) cycle(1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
